// File: rtl/zeroheti_pkg.sv
// Shared types for the zeroHETI APB-to-OBI bridge.
// The optional OBI wait limit is enabled with APB2OBI_TIMEOUT_EN.
package zeroheti_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RSP,
      DONE
   } apb2obi_state_e;

   localparam int unsigned ApbObiTimeout = 32'd255;

endpackage

// File: rtl/zeroheti_apb_to_obi_timer.sv
// Wait-limit counter and stale-response flag for the APB-to-OBI bridge.
// Only instantiated when APB2OBI_TIMEOUT_EN is defined.
module zeroheti_apb_to_obi_timer #(
   parameter int unsigned TimeoutCycles = 32'd255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic active_i,
   input  logic in_rsp_i,
   input  logic rvalid_i,
   output logic timeout_o,
   output logic stale_o
);

   logic [31:0] cnt_q, cnt_d;
   logic        stale_q, stale_d;

   // >= so a grant taken on the limit cycle still times out in RSP
   assign timeout_o = active_i && (cnt_q >= TimeoutCycles - 32'd1);
   assign stale_o   = stale_q;

   always_comb begin
      cnt_d   = active_i ? cnt_q + 32'd1 : '0;
      stale_d = stale_q;
      if (stale_q && rvalid_i) begin
         stale_d = 1'b0;
      end else if (in_rsp_i && timeout_o && !rvalid_i) begin
         stale_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         stale_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         stale_q <= stale_d;
      end
   end

endmodule

// File: rtl/zeroheti_apb_to_obi.sv
// APB subordinate to OBI manager bridge, one OBI transaction per APB transfer.
// Define APB2OBI_TIMEOUT_EN to bound the OBI wait with TimeoutCycles.
module zeroheti_apb_to_obi
   import zeroheti_pkg::*;
#(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = ApbObiTimeout
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   apb_psel_i,
   input  logic                   apb_penable_i,
   input  logic                   apb_pwrite_i,
   input  logic [AddrWidth-1:0]   apb_paddr_i,
   input  logic [DataWidth-1:0]   apb_pwdata_i,
   input  logic [DataWidth/8-1:0] apb_pstrb_i,
   output logic                   apb_pready_o,
   output logic [DataWidth-1:0]   apb_prdata_o,
   output logic                   apb_pslverr_o,
   output logic                   obi_req_o,
   input  logic                   obi_gnt_i,
   output logic [AddrWidth-1:0]   obi_addr_o,
   output logic                   obi_we_o,
   output logic [DataWidth/8-1:0] obi_be_o,
   output logic [DataWidth-1:0]   obi_wdata_o,
   input  logic                   obi_rvalid_i,
   input  logic [DataWidth-1:0]   obi_rdata_i,
   input  logic                   obi_err_i,
   output logic                   obi_rready_o
);

   apb2obi_state_e         state_q, state_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic                   we_q, we_d;
   logic [DataWidth/8-1:0] be_q, be_d;
   logic [DataWidth-1:0]   wdata_q, wdata_d;
   logic [DataWidth-1:0]   prdata_q, prdata_d;
   logic                   pslverr_q, pslverr_d;
   logic                   timeout;
   logic                   stale;

`ifdef APB2OBI_TIMEOUT_EN
   zeroheti_apb_to_obi_timer #(
      .TimeoutCycles(TimeoutCycles)
   ) i_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .active_i ((state_q == REQ) || (state_q == RSP)),
      .in_rsp_i (state_q == RSP),
      .rvalid_i (obi_rvalid_i),
      .timeout_o(timeout),
      .stale_o  (stale)
   );
`else
   logic unused_cfg;
   assign unused_cfg = ^TimeoutCycles;
   assign timeout    = 1'b0;
   assign stale      = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      we_d      = we_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      prdata_d  = prdata_q;
      pslverr_d = pslverr_q;
      unique case (state_q)
         IDLE: begin
            if (apb_psel_i && !apb_penable_i && !stale) begin
               state_d = REQ;
               addr_d  = apb_paddr_i;
               we_d    = apb_pwrite_i;
               be_d    = apb_pwrite_i ? apb_pstrb_i : '1;
               wdata_d = apb_pwdata_i;
            end
         end
         // a grant or response on the limit cycle wins over the timeout
         REQ: begin
            if (obi_gnt_i) begin
               state_d = RSP;
            end else if (timeout) begin
               state_d   = DONE;
               prdata_d  = '0;
               pslverr_d = 1'b1;
            end
         end
         RSP: begin
            if (obi_rvalid_i) begin
               state_d   = DONE;
               prdata_d  = obi_rdata_i;
               pslverr_d = obi_err_i;
            end else if (timeout) begin
               state_d   = DONE;
               prdata_d  = '0;
               pslverr_d = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         wdata_q   <= '0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   assign obi_req_o     = (state_q == REQ);
   assign apb_pready_o  = (state_q == DONE);
   assign obi_addr_o    = addr_q;
   assign obi_we_o      = we_q;
   assign obi_be_o      = be_q;
   assign obi_wdata_o   = wdata_q;
   assign apb_prdata_o  = prdata_q;
   assign apb_pslverr_o = pslverr_q;
   assign obi_rready_o  = 1'b1;

endmodule

// File: tb/tb_zeroheti_apb_to_obi.sv
// Self-checking bench for zeroheti_apb_to_obi.
// Timeout sequences run only when APB2OBI_TIMEOUT_EN is defined.
module tb_zeroheti_apb_to_obi;

`ifdef APB2OBI_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic        pready, pslverr;
   logic [31:0] prdata;
   logic        req, gnt = 1'b0, we, rvalid = 1'b0, err = 1'b0, rready;
   logic [31:0] addr, wdata, rdata = '0;
   logic [3:0]  be;

   int nerr = 0;
   int nchk = 0;
   int ngnt = 0;
   logic [32:0] sb_q[$];

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          gdly;
      int          rdly;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs[5];

   zeroheti_apb_to_obi #(
      .AddrWidth(32),
      .DataWidth(32),
      .TimeoutCycles(TO)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .apb_psel_i   (psel),
      .apb_penable_i(penable),
      .apb_pwrite_i (pwrite),
      .apb_paddr_i  (paddr),
      .apb_pwdata_i (pwdata),
      .apb_pstrb_i  (pstrb),
      .apb_pready_o (pready),
      .apb_prdata_o (prdata),
      .apb_pslverr_o(pslverr),
      .obi_req_o    (req),
      .obi_gnt_i    (gnt),
      .obi_addr_o   (addr),
      .obi_we_o     (we),
      .obi_be_o     (be),
      .obi_wdata_o  (wdata),
      .obi_rvalid_i (rvalid),
      .obi_rdata_i  (rdata),
      .obi_err_i    (err),
      .obi_rready_o (rready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && req && gnt) ngnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic xfer(input vec_t v);
      logic [3:0]  xbe;
      logic [32:0] e;
      xbe = v.wr ? v.strb : 4'hF;
      sb_q.push_back({v.rdata, v.err});
      @(negedge clk);
      chk("pready_low_idle", 32'(pready), 32'd0);
      psel = 1'b1; penable = 1'b0; pwrite = v.wr;
      paddr = v.addr; pwdata = v.wdata; pstrb = v.strb;
      @(negedge clk);
      penable = 1'b1;
      for (int k = 0; k <= v.gdly; k++) begin
         chk("req_held", 32'(req), 32'd1);
         chk("obi_addr", addr, v.addr);
         chk("obi_we", 32'(we), 32'(v.wr));
         chk("obi_be", 32'(be), 32'(xbe));
         if (v.wr) chk("obi_wdata", wdata, v.wdata);
         chk("pready_low_req", 32'(pready), 32'd0);
         if (k == v.gdly) gnt = 1'b1;
         @(negedge clk);
      end
      gnt = 1'b0;
      for (int k = 0; k < v.rdly; k++) begin
         chk("req_low_rsp", 32'(req), 32'd0);
         @(negedge clk);
      end
      chk("req_low_rsp", 32'(req), 32'd0);
      rvalid = 1'b1; rdata = v.rdata; err = v.err;
      @(negedge clk);
      rvalid = 1'b0; rdata = 32'hFFFF_FFFF; err = 1'b0;
      e = sb_q.pop_front();
      chk("pready_done", 32'(pready), 32'd1);
      chk("prdata", prdata, e[32:1]);
      chk("pslverr", 32'(pslverr), 32'(e[0]));
   endtask

   task automatic reset_vals();
      chk("rst_pready", 32'(pready), 32'd0);
      chk("rst_pslverr", 32'(pslverr), 32'd0);
      chk("rst_prdata", prdata, 32'd0);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_addr", addr, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_be", 32'(be), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rready", 32'(rready), 32'd1);
   endtask

   initial begin
      vec_t fr;
      vecs[0] = '{1'b1, 32'h0003_0010, 32'hDEAD_BEEF, 4'b0011, 0, 0,
                  32'h0000_0000, 1'b0};
      vecs[1] = '{1'b0, 32'h0000_1000, 32'h0, 4'b0000, 4, 1,
                  32'h1234_5678, 1'b0};
      vecs[2] = '{1'b0, 32'h0000_2004, 32'h0, 4'b0000, 0, 0,
                  32'hBAD0_0BAD, 1'b1};
      vecs[3] = '{1'b0, 32'h0000_2008, 32'h0, 4'b0000, 2, 0,
                  32'h0BAD_F00D, 1'b0};
      vecs[4] = '{1'b1, 32'h0000_3000, 32'hA5A5_5A5A, 4'b1100, 1, 2,
                  32'h1111_2222, 1'b0};
      fr = '{1'b0, 32'h0000_4000, 32'h0, 4'b0000, 1, 1,
             32'h5555_AAAA, 1'b0};

      repeat (2) @(negedge clk);
      reset_vals();
      rst = 1'b0;

      foreach (vecs[i]) xfer(vecs[i]);
      @(negedge clk);
      chk("pready_single", 32'(pready), 32'd0);
      psel = 1'b0; penable = 1'b0;
      chk("grant_count", 32'(ngnt), 32'd5);

      // abort while req is up: req must fall without a clock edge
      psel = 1'b1; pwrite = 1'b0; paddr = 32'h0000_5000;
      @(negedge clk);
      penable = 1'b1;
      chk("req_before_rst", 32'(req), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_req_drop", 32'(req), 32'd0);
      @(negedge clk);
      rst = 1'b0; psel = 1'b0; penable = 1'b0;

      // abort while waiting for the response
      @(negedge clk);
      psel = 1'b1; paddr = 32'h0000_6000;
      @(negedge clk);
      penable = 1'b1; gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      rst = 1'b1;
      #1;
      chk("rsp_rst_req", 32'(req), 32'd0);
      chk("rsp_rst_pready", 32'(pready), 32'd0);
      @(negedge clk);
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      repeat (2) @(negedge clk);
      chk("rsp_rst_no_pready", 32'(pready), 32'd0);
      xfer(fr);

`ifdef APB2OBI_TIMEOUT_EN
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      psel = 1'b1; paddr = 32'h0000_7000;
      @(negedge clk);
      penable = 1'b1;
      repeat (7) @(negedge clk);
      chk("to_gnt_req", 32'(req), 32'd1);
      chk("to_gnt_pready8", 32'(pready), 32'd0);
      @(negedge clk);
      chk("to_gnt_pready9", 32'(pready), 32'd1);
      chk("to_gnt_slverr", 32'(pslverr), 32'd1);
      chk("to_gnt_prdata", prdata, 32'd0);

      @(negedge clk);
      psel = 1'b1; penable = 1'b0; paddr = 32'h0000_8000;
      @(negedge clk);
      penable = 1'b1; gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      repeat (6) @(negedge clk);
      chk("to_rsp_pready8", 32'(pready), 32'd0);
      @(negedge clk);
      chk("to_rsp_pready9", 32'(pready), 32'd1);
      chk("to_rsp_slverr", 32'(pslverr), 32'd1);
      chk("to_rsp_prdata", prdata, 32'd0);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0;
      @(negedge clk);
      chk("stale_blocks", 32'(req), 32'd0);
      psel = 1'b0; penable = 1'b0;
      rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      rvalid = 1'b0;
      chk("stale_discard", 32'(pready), 32'd0);
      fr.rdata = 32'hCAFE_0042;
      xfer(fr);
`endif

      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
